// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the multi-channel interrupt controller.
// FSM encoding and default geometry.
package intr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam int DEF_N_CH  = 8;
    localparam int DEF_VEC_W = 3;

endpackage

// File: rtl/intr_ctrl_if.sv
// Device/CPU-side bundle of the interrupt controller.
// The master drives lines, mask writes and ack/eoi; the slave answers.
interface intr_ctrl_if
    import intr_ctrl_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int VEC_W = DEF_VEC_W
);
    logic [N_CH-1:0]  intr_in;
    logic             mask_we;
    logic [N_CH-1:0]  mask_wdata;
    logic [N_CH-1:0]  mask;
    logic [N_CH-1:0]  pending;
    logic             intr;
    logic [VEC_W-1:0] vec;
    logic             ack;
    logic             eoi;
    logic             in_service;

    modport master (
        output intr_in, mask_we, mask_wdata, ack, eoi,
        input  mask, pending, intr, vec, in_service
    );

    modport slave (
        input  intr_in, mask_we, mask_wdata, ack, eoi,
        output mask, pending, intr, vec, in_service
    );
endinterface

// File: rtl/intr_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
// Combinational; o_valid flags that any request is present.
module intr_ctrl_prio_enc #(
    parameter int N_CH  = 8,
    parameter int VEC_W = 3
) (
    input  logic [N_CH-1:0]  i_req,
    output logic [VEC_W-1:0] o_idx,
    output logic             o_valid
);
    // Scan downwards so the last hit is the lowest index.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = VEC_W'(i);
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/intr_ctrl.sv
// N-channel interrupt controller: sticky pending, enable mask,
// fixed priority and an ack/EOI handshake towards the CPU.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int              N_CH      = DEF_N_CH,
    parameter int              VEC_W     = DEF_VEC_W,
    parameter logic [N_CH-1:0] EDGE_MODE = {N_CH{1'b1}},
    parameter logic [N_CH-1:0] MASK_RST  = {N_CH{1'b0}}
) (
    input  logic      clk,
    input  logic      rst,
    intr_ctrl_if.slave bus
);
    state_t           r_state;
    logic [N_CH-1:0]  r_pending;
    logic [N_CH-1:0]  r_mask;
    logic [N_CH-1:0]  r_prev;
    logic [VEC_W-1:0] r_vec;
    logic             r_intr;
    logic             r_in_service;

    logic [N_CH-1:0]  w_set;
    logic [N_CH-1:0]  w_clr;
    logic [N_CH-1:0]  w_elig;
    logic [VEC_W-1:0] w_win;
    logic             w_valid;

    // Edge channels fire on 0->1, level channels while high.
    assign w_set = (bus.intr_in & ~r_prev & EDGE_MODE)
                 | (bus.intr_in & ~EDGE_MODE);
    assign w_clr = (r_state == REQ && bus.ack)
                 ? (N_CH'(1) << r_vec) : '0;
    assign w_elig = r_pending & r_mask;

    intr_ctrl_prio_enc #(
        .N_CH  (N_CH),
        .VEC_W (VEC_W)
    ) u_enc (
        .i_req   (w_elig),
        .o_idx   (w_win),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pending    <= '0;
            r_mask       <= MASK_RST;
            r_prev       <= '0;
            r_vec        <= '0;
            r_intr       <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_prev    <= bus.intr_in;
            // Set has priority over the ack clear.
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (bus.mask_we)
                r_mask <= bus.mask_wdata;
            unique case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state <= REQ;
                        r_vec   <= w_win;
                        r_intr  <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.ack) begin
                        r_state      <= SERVICE;
                        r_intr       <= 1'b0;
                        r_in_service <= 1'b1;
                    end else if (!w_elig[r_vec]) begin
                        r_state <= IDLE;
                        r_intr  <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (bus.eoi) begin
                        r_state      <= IDLE;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_intr       <= 1'b0;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mask       = r_mask;
    assign bus.pending    = r_pending;
    assign bus.intr       = r_intr;
    assign bus.vec        = r_vec;
    assign bus.in_service = r_in_service;
endmodule
